// File: rtl/clock_divider.sv
`default_nettype none
// ============================================================================
//  Module   : clock_divider
//  Purpose  : Free-running divider producing three 50%-duty derived clocks
//             from one input clock: divide-by-2, divide-by-3 and a
//             parameterised divide-by-DIV_N. All three outputs rise together
//             on the first counted rising edge after reset release.
//
//  Ports    : clk   in   input clock; rising edges are the counting
//                        reference, falling edges are used only to stretch
//                        odd-ratio outputs by half a period
//             nrst  in   asynchronous reset, active HIGH (nrst=1 resets)
//             out2  out  clk / 2, 50% duty
//             out3  out  clk / 3, 50% duty (high 1.5 clk periods)
//             outn  out  clk / DIV_N, 50% duty
//
//  Params   : DIV_N  divide ratio of outn, legal range 2..255
//             CNT_W  counter width, derived from DIV_N (do not override)
//
//  Revision : 1.0  initial release
// ============================================================================
module clock_divider #(
    parameter int DIV_N = 5,
    parameter int CNT_W = $clog2(DIV_N)
) (
    input  logic clk,
    input  logic nrst,
    output logic out2,
    output logic out3,
    output logic outn
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (DIV_N < 2 || DIV_N > 255) begin : g_bad_div_n
            $error("clock_divider: DIV_N=%0d outside legal range 2..255", DIV_N);
        end
        if (CNT_W != $clog2(DIV_N)) begin : g_bad_cnt_w
            $error("clock_divider: CNT_W must equal $clog2(DIV_N)");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The rising-edge flop of a divider is high for DIV_N/2 whole periods.
    // For even ratios that is exactly half the period. For odd ratios it is
    // (DIV_N-1)/2 periods, and the falling-edge copy adds the missing half.
    localparam logic [CNT_W-1:0] c_cntn_last = CNT_W'(DIV_N - 1);
    localparam logic [CNT_W-1:0] c_cntn_high = CNT_W'(DIV_N / 2);
    localparam logic [1:0]       c_cnt3_last = 2'd2;

    // ------------------------------------------------------------------------
    // Divide-by-2: a plain toggle flop
    // ------------------------------------------------------------------------
    logic r_out2;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_out2 <= 1'b0;
        end else begin
            r_out2 <= ~r_out2;
        end
    end

    assign out2 = r_out2;

    // ------------------------------------------------------------------------
    // Divide-by-3
    //
    // r_cnt3 holds (k-1) mod 3 just before counted edge k, so sampling
    // "count == 0" into r_out3_pos makes it high for the period that starts
    // at every edge k = 1 mod 3. r_out3_neg repeats that pulse half a period
    // later; their OR is high for 1.5 periods. The two flops switch on
    // opposite clock edges, so the OR inputs never change together and the
    // output cannot glitch.
    // ------------------------------------------------------------------------
    logic [1:0] r_cnt3;
    logic       r_out3_pos;
    logic       r_out3_neg;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_cnt3     <= 2'd0;
            r_out3_pos <= 1'b0;
        end else begin
            r_cnt3     <= (r_cnt3 == c_cnt3_last) ? 2'd0 : r_cnt3 + 2'd1;
            r_out3_pos <= (r_cnt3 == 2'd0);
        end
    end

    always_ff @(negedge clk or posedge nrst) begin
        if (nrst) begin
            r_out3_neg <= 1'b0;
        end else begin
            r_out3_neg <= r_out3_pos;
        end
    end

    assign out3 = r_out3_pos | r_out3_neg;

    // ------------------------------------------------------------------------
    // Divide-by-DIV_N
    //
    // r_cntn holds (k-1) mod DIV_N just before counted edge k. The decode of
    // the counter only feeds a flop; the output is always taken from flops.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_cntn;
    logic             r_outn_pos;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_cntn     <= '0;
            r_outn_pos <= 1'b0;
        end else begin
            r_cntn     <= (r_cntn == c_cntn_last) ? '0 : r_cntn + CNT_W'(1);
            r_outn_pos <= (r_cntn < c_cntn_high);
        end
    end

    generate
        if ((DIV_N % 2) == 0) begin : g_outn_even
            // Even ratio: rising-edge flop alone is already 50% duty.
            assign outn = r_outn_pos;
        end else begin : g_outn_odd
            // Odd ratio: stretch by half a period with a falling-edge copy,
            // combined the same glitch-free way as the divide-by-3 path.
            logic r_outn_neg;

            always_ff @(negedge clk or posedge nrst) begin
                if (nrst) begin
                    r_outn_neg <= 1'b0;
                end else begin
                    r_outn_neg <= r_outn_pos;
                end
            end

            assign outn = r_outn_pos | r_outn_neg;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clock_divider.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : tb_clock_divider
//  Purpose  : Self-checking bench for clock_divider. Six instances with
//             DIV_N in {2,3,4,5,7,8} share one clock and reset. Expected
//             levels come from a hand table for the first periods and from a
//             half-period slot model for long runs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_divider;

    localparam int          c_num       = 6;
    localparam logic [47:0] c_ns_packed = {8'd8, 8'd7, 8'd5, 8'd4, 8'd3, 8'd2};
    localparam int          c_g_n5      = 3;   // instance with DIV_N=5

    logic             clk;
    logic             nrst;
    logic [c_num-1:0] o2;
    logic [c_num-1:0] o3;
    logic [c_num-1:0] on;

    int total = 0;
    int bad   = 0;
    int k     = 0;          // counted rising edges since reset release
    int glitches = 0;

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < c_num; g++) begin : g_dut
        clock_divider #(
            .DIV_N (int'(c_ns_packed[g*8 +: 8]))
        ) u_dut (
            .clk  (clk),
            .nrst (nrst),
            .out2 (o2[g]),
            .out3 (o3[g]),
            .outn (on[g])
        );
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic int n_of(input int g);
        logic [47:0] v;
        v = c_ns_packed;
        return int'(v[g*8 +: 8]);
    endfunction

    // Divide-by-n level in the half-period slot after counted edge kk
    // (half=0: after the rising edge, half=1: after the following falling
    // edge). A 50%-duty divide-by-n is high for the first n of its 2n slots.
    function automatic logic model(input int n, input int kk, input int half);
        if (kk <= 0) return 1'b0;
        return ((2 * ((kk - 1) % n) + half) < n);
    endfunction

    task automatic chk(input string name, input int g, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[N=%0d] t=%0t k=%0d got=%b want=%b",
                     name, n_of(g), $time, k, got, exp);
        end
    endtask

    task automatic check_zero();
        for (int g = 0; g < c_num; g++) begin
            chk("rst_out2", g, o2[g], 1'b0);
            chk("rst_out3", g, o3[g], 1'b0);
            chk("rst_outn", g, on[g], 1'b0);
        end
    endtask

    task automatic check_all(input int half);
        for (int g = 0; g < c_num; g++) begin
            chk("out2", g, o2[g], model(2, k, half));
            chk("out3", g, o3[g], model(3, k, half));
            chk("outn", g, on[g], model(n_of(g), k, half));
        end
    endtask

    task automatic run_periods(input int n);
        repeat (n) begin
            @(posedge clk);
            k++;
            #3;
            check_all(0);
            @(negedge clk);
            #3;
            check_all(1);
        end
    endtask

    function automatic logic sig(input int sel);
        if (sel == 0) return o2[c_g_n5];
        if (sel == 1) return o3[c_g_n5];
        return on[sel-2];
    endfunction

    task automatic wait_level(input int sel, input logic lvl, output real t, output bit ok);
        ok = 1'b0;
        t  = 0.0;
        for (int i = 0; i < 400; i++) begin
            if (sig(sel) === lvl) begin
                ok = 1'b1;
                t  = $realtime;
                break;
            end
            #1;
        end
    endtask

    task automatic wait_edge(input int sel, input logic lvl, output real t, output bit ok);
        bit ok1;
        real tdummy;
        wait_level(sel, ~lvl, tdummy, ok1);
        wait_level(sel, lvl, t, ok);
        ok = ok & ok1;
    endtask

    // High time and period of one output over three consecutive periods.
    task automatic measure(input int sel, input int n);
        real t_r1, t_f, t_r2;
        bit  ok_a, ok_b, ok_c;
        #0.5;  // poll off the 5 ns edge grid
        wait_edge(sel, 1'b1, t_r1, ok_a);
        repeat (3) begin
            wait_edge(sel, 1'b0, t_f, ok_b);
            wait_edge(sel, 1'b1, t_r2, ok_c);
            total++;
            if (!(ok_a && ok_b && ok_c)) begin
                bad++;
                $display("FAIL measure_timeout sel=%0d N=%0d no edge within bound", sel, n);
                return;
            end
            if ((t_f - t_r1) > n*5.0 + 0.2 || (t_f - t_r1) < n*5.0 - 0.2 ||
                (t_r2 - t_r1) > n*10.0 + 0.2 || (t_r2 - t_r1) < n*10.0 - 0.2) begin
                bad++;
                $display("FAIL duty sel=%0d N=%0d high=%0.1f period=%0.1f want high=%0.1f period=%0.1f",
                         sel, n, t_f - t_r1, t_r2 - t_r1, n*5.0, n*10.0);
            end
            t_r1 = t_r2;
        end
    endtask

    // ------------------------------------------------------------------------
    // Zero-delay glitch monitor: outside reset no output may toggle twice
    // within one half period of clk.
    // ------------------------------------------------------------------------
    logic [7:0] mon;
    logic [7:0] prev_mon;
    real        last_t [8];

    assign mon = {on, o3[c_g_n5], o2[c_g_n5]};

    initial begin
        prev_mon = 8'h00;
        for (int i = 0; i < 8; i++) last_t[i] = -100.0;
    end

    always @(mon) begin
        for (int i = 0; i < 8; i++) begin
            if (mon[i] !== prev_mon[i]) begin
                if (nrst === 1'b0 && ($realtime - last_t[i]) < 4.9) glitches++;
                last_t[i] = $realtime;
            end
        end
        prev_mon = mon;
    end

    // ------------------------------------------------------------------------
    // Vector table: first six periods of the instance with DIV_N=5
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic after_fall;   // input: sample after falling (1) or rising (0) edge
        logic e2;
        logic e3;
        logic e5;
    } vec_t;

    vec_t tbl [12];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset hold for three clock periods with clk running.
        nrst = 1'b1;
        k    = 0;
        #1;
        repeat (6) begin
            check_zero();
            #5;
        end
        #1;                       // t = 32, away from clk edges
        nrst = 1'b0;

        // Table-driven first six periods (k=1 at t=35).
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].after_fall) begin
                @(negedge clk);
            end else begin
                @(posedge clk);
                k++;
            end
            #3;
            chk("tbl_out2", c_g_n5, o2[c_g_n5], tbl[i].e2);
            chk("tbl_out3", c_g_n5, o3[c_g_n5], tbl[i].e3);
            chk("tbl_outn", c_g_n5, on[c_g_n5], tbl[i].e5);
        end

        // Long run against the slot model, all instances.
        run_periods(40);

        // Mid-operation reset while out3 is held high only by its
        // falling-edge flop (just after a rising edge with k mod 3 = 2).
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            k++;
            if (k % 3 == 2) break;
        end
        #2;
        for (int g = 0; g < c_num; g++) chk("pre_rst_out3", g, o3[g], model(3, k, 0));
        nrst = 1'b1;
        #1;
        check_zero();
        #3;
        check_zero();
        #1;                       // 2 ns after falling edge, 3 ns before rising
        nrst = 1'b0;
        k    = 0;
        #2;
        check_zero();             // still before k=1
        run_periods(24);

        // Duty / period measurements.
        for (int s = 0; s < 8; s++) begin
            measure(s, (s == 0) ? 2 : (s == 1) ? 3 : n_of(s - 2));
        end

        total++;
        if (glitches != 0) begin
            bad++;
            $display("FAIL glitch count got=%0d want=0", glitches);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
